core_reset_cen: RTL and testbench
=================================

Name: core_reset_cen

Overview:
- Sits directly downstream of the core PLL and runs in its 96 MHz primary output domain.
- Consumes the PLL's asynchronous `locked` flag and produces a qualified, synchronous core reset.
- Also produces the 12 MHz and 6 MHz single-cycle clock enables (plus a 180°-offset 6 MHz enable) that all core logic uses in place of separate derived clocks.
- Guarantees that the enables start in a known phase relationship to reset release, and that any loss of lock re-asserts reset.

Parameters:
- SYNC_STAGES, 2: depth of the synchronizer chain on `locked`. Must be ≥2.
- HOLD_CYCLES, 1024: number of clk cycles reset is held after synchronized lock is seen. Must be ≥1.

Ports:
- clk  in  1  96 MHz system clock (PLL outclk_0).
- rst  in  1  synchronous active-high reset (bridge/host reset).
- locked  in  1  PLL lock flag; asynchronous to clk.
- core_rst  out  1  synchronous active-high reset to core logic.
- ready  out  1  high while the block is in RUN.
- cen_12  out  1  one-clk pulse every 8 clks (12 MHz enable).
- cen_6  out  1  one-clk pulse every 16 clks (6 MHz enable).
- cen_6_180  out  1  6 MHz enable, offset 8 clks from cen_6.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high; no asynchronous reset anywhere in the block.
- Reset values (`rst` high, or power-on):
  - Outputs: core_rst=1, ready=0, cen_12=0, cen_6=0, cen_6_180=0.
  - Internal: state=WAIT_LOCK, sync chain all 0, hold_cnt=0, div_cnt=0.
- `rst` priority: overrides all other conditions on every cycle. It may arrive in any state and takes effect on the next edge.
- Synchronizer: `locked` passes through SYNC_STAGES flops. The last stage is lock_s. No other logic samples `locked` directly.
- State machine (registered, three states):
  - WAIT_LOCK: hold_cnt=0. If lock_s=1, go to HOLD.
  - HOLD: if lock_s=0, go to WAIT_LOCK and clear hold_cnt. Otherwise hold_cnt increments. When hold_cnt==HOLD_CYCLES-1, go to RUN.
  - RUN: if lock_s=0, go to WAIT_LOCK. Otherwise stay.
- Outputs from state:
  - core_rst = (state != RUN), decoded from the state register.
  - ready = (state == RUN).
- Release latency: with `locked` rising before edge 1 and held high, state enters HOLD at edge SYNC_STAGES+1. core_rst falls at edge SYNC_STAGES+1+HOLD_CYCLES (1027 with defaults).
- Lock loss in RUN: core_rst re-asserts at the edge after lock_s falls, i.e. SYNC_STAGES+1 edges after `locked` falls. Enables drop in the same cycle.
- Lock glitch in HOLD: hold restarts from zero. A full HOLD_CYCLES of continuous lock is required.
- Lock pulses shorter than one clk may be missed; no filtering beyond the synchronizer.
- hold_cnt width: clog2(HOLD_CYCLES). It never exceeds HOLD_CYCLES-1 and never wraps.
- div_cnt: 4-bit.
  - Forced to 0 whenever state != RUN.
  - Increments every clk in RUN and wraps 15 → 0.
  - The first RUN cycle has div_cnt=0.
- Enable decodes (combinational from div_cnt and state; all forced 0 outside RUN):
  - cen_12 = RUN & div_cnt[2:0]==7.
  - cen_6 = RUN & div_cnt==15.
  - cen_6_180 = RUN & div_cnt==7.
- Enable phase:
  - First cen_12 pulse: 8th RUN cycle. First cen_6 pulse: 16th RUN cycle. First cen_6_180 pulse: 8th RUN cycle.
  - cen_6 and cen_6_180 are never high together. cen_12 is high whenever either is high.
- Simultaneous events:
  - lock_s falling on the same edge as the HOLD → RUN transition: WAIT_LOCK wins.
  - `rst` together with any transition: `rst` wins.

Test Plan:
- Power-up with `rst` high 4 cycles, `locked`=0 → core_rst=1, ready=0, all cen=0 throughout; state stays WAIT_LOCK.
- HOLD_CYCLES=16, `locked` rises before edge 1 and held → core_rst falls exactly at edge 19 and ready rises at edge 19.
- Continuing that case, in RUN → cen_12 pulses at RUN cycles 8, 16, 24…; cen_6 at 16, 32…; cen_6_180 at 8, 24…; cen_6 & cen_6_180 never both high.
- `locked` drops for 3 clks while hold_cnt=10 → return to WAIT_LOCK. After `locked` re-rises, core_rst falls a full 19 edges later (no credit for the earlier partial hold).
- `locked` drops in RUN → core_rst=1 and all cen=0 at edge SYNC_STAGES+1 after the fall; div_cnt restarts at 0 on the next RUN entry.
- `rst` pulsed one cycle while in RUN with `locked` steady → core_rst=1 next edge; re-release after SYNC_STAGES+1+HOLD_CYCLES edges, because the sync chain was cleared.

Source files
------------

// File: rtl/core_reset_cen.sv
// rtl/core_reset_cen.sv - PLL-lock qualified core reset and 12/6 MHz clock-enable generator
// Runs in the 96 MHz PLL domain; all core logic uses these enables instead of derived clocks.
module core_reset_cen #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    output logic core_rst,
    output logic ready,
    output logic cen_12,
    output logic cen_6,
    output logic cen_6_180
);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q, state_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [3:0]             div_cnt_q, div_cnt_d;
    logic                   lock_s;
    logic                   run;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_WAIT_LOCK: begin
                hold_cnt_d = '0;
                if (lock_s) state_d = S_HOLD;
            end
            S_HOLD: begin
                // Any gap in lock discards all accumulated hold time.
                if (!lock_s) begin
                    state_d    = S_WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                hold_cnt_d = '0;
                if (!lock_s) state_d = S_WAIT_LOCK;
            end
            default: begin
                state_d    = S_WAIT_LOCK;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Divider starts at 0 on the first RUN cycle so enable phase is fixed to reset release.
    assign div_cnt_d = (state_q == S_RUN && state_d == S_RUN) ? div_cnt_q + 4'd1 : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= S_WAIT_LOCK;
            hold_cnt_q <= '0;
            div_cnt_q  <= 4'd0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], locked};
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

    assign run       = (state_q == S_RUN);
    assign core_rst  = !run;
    assign ready     = run;
    assign cen_12    = run && (div_cnt_q[2:0] == 3'd7);
    assign cen_6     = run && (div_cnt_q == 4'd15);
    assign cen_6_180 = run && (div_cnt_q == 4'd7);

endmodule

// File: tb/tb_core_reset_cen.sv
// tb/tb_core_reset_cen.sv - bench for core_reset_cen against a lock-streak reference model
module tb_core_reset_cen;

    localparam int SYNC = 2;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    logic locked;
    logic core_rst, ready, cen_12, cen_6, cen_6_180;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: locked samples seen by the synchronizer, and the count of
    // consecutive edges at which the synchronized lock was high.
    int q[$];
    int streak = 0;

    core_reset_cen #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .core_rst  (core_rst),
        .ready     (ready),
        .cen_12    (cen_12),
        .cen_6     (cen_6),
        .cen_6_180 (cen_6_180)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic l);
        int  ls;
        bit  run;
        int  d;
        rst    = r;
        locked = l;
        if (r) begin
            q.delete();
            streak = 0;
        end else begin
            ls = (q.size() >= SYNC) ? q[q.size() - SYNC] : 0;
            q.push_back(int'(l));
            if (q.size() > SYNC) void'(q.pop_front());
            streak = (ls != 0) ? streak + 1 : 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        run = (streak > HOLD);
        d   = run ? (streak - HOLD - 1) % 16 : 0;
        chk("core_rst", int'(core_rst), int'(!run));
        chk("ready", int'(ready), int'(run));
        chk("cen_12", int'(cen_12), int'(run && (d % 8 == 7)));
        chk("cen_6", int'(cen_6), int'(run && d == 15));
        chk("cen_6_180", int'(cen_6_180), int'(run && d == 7));
        chk("cen6_excl", int'(cen_6 && cen_6_180), 0);
    endtask

    task automatic run_until_ready(input int budget, output int edges);
        edges = 0;
        do begin
            step(1'b0, 1'b1);
            edges++;
        end while (!ready && edges < budget);
    endtask

    initial begin
        int n;
        int c12, c6, c6b;
        int len;
        logic lv;

        rst    = 1'b1;
        locked = 1'b0;

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

        // Release from a clean reset: expect ready at edge SYNC+1+HOLD.
        run_until_ready(100, n);
        chk("release_edges", n, SYNC + 1 + HOLD);

        c12 = 0; c6 = 0; c6b = 0;
        for (int i = 0; i < 48; i++) begin
            step(1'b0, 1'b1);
            c12 += int'(cen_12);
            c6  += int'(cen_6);
            c6b += int'(cen_6_180);
        end
        chk("cnt_cen_12", c12, 6);
        chk("cnt_cen_6", c6, 3);
        chk("cnt_cen_6_180", c6b, 3);

        // Lock loss in RUN.
        n = 0;
        do begin
            step(1'b0, 1'b0);
            n++;
        end while (!core_rst && n < 20);
        chk("lockloss_edges", n, SYNC + 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Lock glitch mid-hold gives no credit.
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        run_until_ready(100, n);
        chk("rehold_edges", n, SYNC + 1 + HOLD);

        // Reset pulse in RUN clears the synchronizer too.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_pulse_core_rst", int'(core_rst), 1);
        run_until_ready(100, n);
        chk("rst_rerelease_edges", n, SYNC + 1 + HOLD);

        // Randomized lock behaviour with occasional host resets.
        lv = 1'b1;
        for (int k = 0; k < 120; k++) begin
            lv  = ~lv;
            len = lv ? $urandom_range(1, 60) : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, lv);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
